// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 chunk loader.
// Defines the loader state encoding and the single-block padding limits.
package md5_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_LOAD,
      ST_PAD,
      ST_CRST,
      ST_START,
      ST_WAIT,
      ST_RESULT
   } state_t;

   localparam logic [7:0] PAD_BYTE    = 8'h80;
   localparam int         MAX_MSG_LEN = 55;
   localparam int         LEN_W       = 6;

endpackage

// File: rtl/pad_word.sv
// Combinational MD5 padding of one 32-bit buffer word given the message length.
// Bytes below len are kept, byte len becomes 0x80, later bytes clear; word 14 holds the bit length.
module pad_word
   import md5_pkg::*;
(
   input  logic [3:0]       widx,
   input  logic [31:0]      old_word,
   input  logic [LEN_W-1:0] len,
   output logic [31:0]      new_word
);

   logic [5:0] k;

   always_comb begin
      new_word = '0;
      k        = '0;
      if (widx == 4'd14) begin
         new_word = {23'b0, len, 3'b0};
      end else if (widx != 4'd15) begin
         for (int unsigned b = 0; b < 4; b++) begin
            k = {widx, b[1:0]};
            if (k < len)
               new_word[8*b +: 8] = old_word[8*b +: 8];
            else if (k == len)
               new_word[8*b +: 8] = PAD_BYTE;
         end
      end
   end

endmodule

// File: rtl/chunk_loader.sv
// Builds one padded MD5 block from a byte stream and sequences the chunk cruncher through it.
// Returns the cruncher digest and message length on a valid/ready output port.
module chunk_loader
   import md5_pkg::*;
#(
   parameter int MAX_LEN = MAX_MSG_LEN
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             crunch_reset,
   output logic             crunch_start,
   input  logic             crunch_done,
   input  logic [3:0]       crunch_gaddr,
   output logic [31:0]      crunch_mdata,
   input  logic [127:0]     crunch_digest,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_digest,
   output logic [LEN_W-1:0] out_len,
   output logic             len_err
);

   state_t           state;
   logic [LEN_W-1:0] cnt;
   logic [3:0]       widx;
   logic [31:0]      mem [16];
   logic [31:0]      pad_out;

   pad_word u_pad (
      .widx     (widx),
      .old_word (mem[widx]),
      .len      (out_len),
      .new_word (pad_out)
   );

   assign crunch_mdata = mem[crunch_gaddr];

   // Control outputs are registered alongside the state so each is a pure function of state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_INIT;
         cnt          <= '0;
         widx         <= '0;
         out_len      <= '0;
         for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
         in_ready     <= 1'b0;
         crunch_reset <= 1'b1;
         crunch_start <= 1'b0;
         out_valid    <= 1'b0;
         out_digest   <= '0;
         len_err      <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               crunch_reset <= 1'b0;
               in_ready     <= 1'b1;
               state        <= ST_LOAD;
            end
            ST_LOAD: begin
               if (in_valid) begin
                  mem[cnt[5:2]][{cnt[1:0], 3'b000} +: 8] <= in_data;
                  cnt <= cnt + 6'd1;
                  if (in_last || cnt == 6'(MAX_LEN - 1)) begin
                     out_len  <= cnt + 6'd1;
                     len_err  <= ~in_last;
                     in_ready <= 1'b0;
                     widx     <= '0;
                     state    <= ST_PAD;
                  end
               end
            end
            ST_PAD: begin
               mem[widx] <= pad_out;
               widx      <= widx + 4'd1;
               if (widx == 4'd15) begin
                  crunch_reset <= 1'b1;
                  state        <= ST_CRST;
               end
            end
            ST_CRST: begin
               crunch_reset <= 1'b0;
               crunch_start <= 1'b1;
               state        <= ST_START;
            end
            ST_START: begin
               crunch_start <= 1'b0;
               state        <= ST_WAIT;
            end
            ST_WAIT: begin
               if (crunch_done) begin
                  out_digest <= crunch_digest;
                  out_valid  <= 1'b1;
                  state      <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  cnt       <= '0;
                  len_err   <= 1'b0;
                  state     <= ST_LOAD;
               end
            end
            default: begin
               crunch_reset <= 1'b1;
               in_ready     <= 1'b0;
               out_valid    <= 1'b0;
               crunch_start <= 1'b0;
               state        <= ST_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chunk_loader.sv
// Bench for chunk_loader: an MD5 cruncher model serves the block reads, a scoreboard checks
// each digest/length/error/padded block at the output handshake.
module tb_chunk_loader;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_last = 1'b0;
   logic [7:0]   in_data = '0;
   logic         out_ready = 1'b1;
   logic         in_ready, crunch_reset, crunch_start, out_valid, len_err;
   logic [31:0]  crunch_mdata;
   logic [127:0] out_digest;
   logic [5:0]   out_len;

   logic         cr_done = 1'b0;
   logic [3:0]   cr_gaddr = '0;
   logic [127:0] cr_digest = '0;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   chunk_loader #(.MAX_LEN(55)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .crunch_reset  (crunch_reset),
      .crunch_start  (crunch_start),
      .crunch_done   (cr_done),
      .crunch_gaddr  (cr_gaddr),
      .crunch_mdata  (crunch_mdata),
      .crunch_digest (cr_digest),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_digest    (out_digest),
      .out_len       (out_len),
      .len_err       (len_err)
   );

   localparam logic [31:0] K [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
   localparam int S [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
   localparam logic [127:0] ST0 = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};

   // One MD5 compression; state and result packed {d,c,b,a}.
   function automatic logic [127:0] md5_step(input logic [127:0] st, input logic [511:0] blk);
      logic [31:0] a, b, c, d, f, t;
      int unsigned g, s;
      a = st[31:0]; b = st[63:32]; c = st[95:64]; d = st[127:96];
      for (int unsigned i = 0; i < 64; i++) begin
         if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
         else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
         else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
         else             begin f = c ^ (b | ~d);       g = (7*i) % 16; end
         s = S[(i/16)*4 + i%4];
         t = f + a + K[i] + blk[32*g +: 32];
         a = d; d = c; c = b;
         b = b + ((t << s) | (t >> (32 - s)));
      end
      return {st[127:96] + d, st[95:64] + c, st[63:32] + b, st[31:0] + a};
   endfunction

   // Cruncher model: reads the 16 words via gaddr after start, digest accumulates until crunch_reset.
   logic [127:0] cr_state = ST0;
   logic [511:0] cr_blk = '0;
   logic [511:0] last_blk = '0;
   bit           cr_busy = 1'b0;

   always @(posedge clk) begin
      logic [511:0] nb;
      logic [127:0] h;
      if (crunch_reset) begin
         cr_state <= ST0;
         cr_done  <= 1'b0;
         cr_busy  <= 1'b0;
      end else if (crunch_start) begin
         cr_done  <= 1'b0;
         cr_busy  <= 1'b1;
         cr_gaddr <= '0;
      end else if (cr_busy) begin
         nb = cr_blk;
         nb[32*cr_gaddr +: 32] = crunch_mdata;
         cr_blk <= nb;
         if (cr_gaddr == 4'd15) begin
            h = md5_step(cr_state, nb);
            cr_state  <= h;
            cr_digest <= h;
            last_blk  <= nb;
            cr_done   <= 1'b1;
            cr_busy   <= 1'b0;
         end else begin
            cr_gaddr <= cr_gaddr + 4'd1;
         end
      end
   end

   typedef struct {
      logic [127:0] dig;
      logic [5:0]   len;
      logic         err;
      logic [511:0] blk;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("digest", out_digest, mon_e.dig);
            chk("out_len", out_len, mon_e.len);
            chk("len_err", len_err, mon_e.err);
            chk("padded_block", last_blk, mon_e.blk);
         end
      end
   end

   task automatic send_bytes(input logic [7:0] msg[$], input bit last_on_final);
      int n;
      for (int i = 0; i < msg.size(); i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = msg[i];
         in_last  = last_on_final && (i == msg.size() - 1);
         n = 0;
         while (!in_ready && n < 200) begin @(negedge clk); n++; end
         if (n >= 200) begin
            chk("in_ready_timeout", 0, 1);
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin @(negedge clk); n++; end
      chk("drain", sb.size(), 0);
   endtask

   task automatic push(input logic [127:0] d, input logic [5:0] l, input logic e, input logic [511:0] b);
      exp_t x;
      x.dig = d; x.len = l; x.err = e; x.blk = b;
      sb.push_back(x);
   endtask

   localparam logic [127:0] DIG_ABC = 128'h727fe1287d3f96d6b04fd23c98500190;
   localparam logic [127:0] DIG_A   = 128'h61267769e299c331a8b6f1c0b975c10c;

   initial begin
      logic [7:0]   m_abc[$];
      logic [7:0]   m_a[$];
      logic [7:0]   m55[$];
      logic [511:0] blk_abc, blk_a, blk55;
      logic [127:0] dig0;
      int           bad, n;

      m_abc = '{8'h61, 8'h62, 8'h63};
      m_a   = '{8'h61};
      for (int i = 0; i < 55; i++) m55.push_back(8'h41);
      blk_abc = '0; blk_abc[31:0] = 32'h80636261; blk_abc[14*32 +: 32] = 32'h18;
      blk_a   = '0; blk_a[31:0]   = 32'h00008061; blk_a[14*32 +: 32]   = 32'h8;
      blk55   = '0;
      for (int i = 0; i < 13; i++) blk55[32*i +: 32] = 32'h41414141;
      blk55[13*32 +: 32] = 32'h80414141;
      blk55[14*32 +: 32] = 32'h1B8;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_crunch_reset", crunch_reset, 1);
      chk("rst_crunch_start", crunch_start, 0);
      chk("rst_len_err", len_err, 0);
      chk("rst_mdata", crunch_mdata, 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("init_to_load_in_ready", in_ready, 1);

      push(DIG_ABC, 6'd3, 1'b0, blk_abc);
      send_bytes(m_abc, 1'b1);
      wait_drain();

      // back-to-back: crunch_reset per message and stale-byte clearing
      push(DIG_A, 6'd1, 1'b0, blk_a);
      push(DIG_ABC, 6'd3, 1'b0, blk_abc);
      send_bytes(m_a, 1'b1);
      send_bytes(m_abc, 1'b1);
      wait_drain();

      push(md5_step(ST0, blk55), 6'd55, 1'b0, blk55);
      send_bytes(m55, 1'b1);
      wait_drain();

      // 56 bytes without last: truncated at 55
      push(md5_step(ST0, blk55), 6'd55, 1'b1, blk55);
      send_bytes(m55, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h41; in_last = 1'b0;
      chk("ovf_in_ready_low", in_ready, 0);
      @(negedge clk);
      in_valid = 1'b0;
      wait_drain();
      @(negedge clk);
      chk("len_err_cleared", len_err, 0);

      // hold result with out_ready low
      @(posedge clk); #1 out_ready = 1'b0;
      push(DIG_ABC, 6'd3, 1'b0, blk_abc);
      send_bytes(m_abc, 1'b1);
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      chk("hold_out_valid", out_valid, 1);
      dig0 = out_digest;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!out_valid || out_digest !== dig0 || in_ready) bad++;
      end
      chk("hold_stable", bad, 0);
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_in_ready", in_ready, 1);
      chk("release_sb_empty", sb.size(), 0);

      // reset pulse during WAIT: message is dropped
      send_bytes(m_abc, 1'b1);
      n = 0;
      while (!crunch_start && n < 200) begin @(negedge clk); n++; end
      chk("saw_crunch_start", crunch_start, 1);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort_crunch_reset", crunch_reset, 1);
      chk("abort_in_ready", in_ready, 0);
      reset_n = 1'b1;
      #1;
      chk("init_crunch_reset", crunch_reset, 1);
      @(negedge clk);
      chk("post_init_in_ready", in_ready, 1);
      chk("post_init_crunch_reset", crunch_reset, 0);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) bad++;
      end
      chk("abort_no_output", bad, 0);

      // recovery after abort
      push(DIG_A, 6'd1, 1'b0, blk_a);
      send_bytes(m_a, 1'b1);
      wait_drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
      $fatal(1);
   end

endmodule
